// File: rtl/uart_riscv_rx.sv
// uart_riscv_rx: 8N1 UART receiver with a one-byte holding register.
// The line is synchronised, each bit is sampled at its midpoint, and the
// stop bit is checked. A good frame lands in rx_data with rx_valid set.
// Status flags are sticky until the core reads through cs_uart_rx & rd_en.
module uart_riscv_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    input  logic                 cs_uart_rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Last count of a full bit period and of the half period used to reach
    // the middle of the start bit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0]       bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [DATA_BITS-1:0]   shift_in;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    logic [DATA_BITS-1:0]   rx_data_reg;
    logic                   rx_valid_reg;
    logic                   frame_err_reg;
    logic                   overrun_reg;

    logic                   accept;
    logic                   ferr_set;
    logic                   rd;
    logic                   ovr_set;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_serial};
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // New sampled bit enters at the MSB so the first (LSB) bit ends at bit 0.
    generate
        if (DATA_BITS == 1) begin : g_shift_one
            assign shift_in = rx_s;
        end else begin : g_shift_many
            assign shift_in = {rx_s, shift_reg[DATA_BITS-1:1]};
        end
    endgenerate

    // Receive FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    // Next-state logic: timer runs freely and is cleared on entry and after
    // every sample; accept/ferr_set pulse in the stop-sample cycle.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + CNT_W'(1);
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        accept       = 1'b0;
        ferr_set     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next   = S_DATA;
                        bit_idx_next = '0;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = shift_in;
                    if (bit_idx_reg == IDX_LAST) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + IDX_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        accept     = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Hold here until the line returns high so a stuck-low line
                // cannot start a new frame.
                cnt_next = '0;
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign rd      = cs_uart_rx & rd_en;
    // A read in the accept cycle consumes the old byte, so no overrun then.
    assign ovr_set = accept & rx_valid_reg & ~rd;

    // Holding register and sticky status; any set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (accept) begin
                rx_data_reg <= shift_reg;
            end

            if (accept) begin
                rx_valid_reg <= 1'b1;
            end else if (rd) begin
                rx_valid_reg <= 1'b0;
            end

            if (ferr_set) begin
                frame_err_reg <= 1'b1;
            end else if (rd) begin
                frame_err_reg <= 1'b0;
            end

            if (ovr_set) begin
                overrun_reg <= 1'b1;
            end else if (rd) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_riscv_rx.sv
// tb_uart_riscv_rx: directed frames at 16 clocks per bit with hand-computed
// expected register values for the UART receiver.
module tb_uart_riscv_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx_serial;
    logic       cs_uart_rx;
    logic       rd_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_riscv_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_serial),
        .cs_uart_rx(cs_uart_rx),
        .rd_en     (rd_en),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start bit, nbits data bits LSB first, then (full frames only) the stop
    // bit. The line is left at the last driven level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        @(posedge clk);
        #1 rx_serial = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx_serial = b[i];
        end
        if (nbits == 8) begin
            repeat (CPB) @(posedge clk);
            #1 rx_serial = stop_bit;
            repeat (CPB) @(posedge clk);
            #1;
        end
        $display("frame 0x%02h stop=%0d bits=%0d driven", b, stop_bit, nbits);
    endtask

    task automatic do_read();
        @(posedge clk);
        #1 cs_uart_rx = 1'b1;
        rd_en = 1'b1;
        @(posedge clk);
        #1 cs_uart_rx = 1'b0;
        rd_en = 1'b0;
        $display("read strobe issued");
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        rx_serial  = 1'b1;
        cs_uart_rx = 1'b0;
        rd_en      = 1'b0;
        wait_cycles(3);
        check_eq("rst_data",  rx_data, 8'h00);
        check_eq("rst_valid", rx_valid, 1'b0);
        check_eq("rst_ferr",  frame_err, 1'b0);
        check_eq("rst_ovr",   overrun, 1'b0);
        check_eq("rst_busy",  busy, 1'b0);
        rst = 1'b0;
        wait_cycles(4);

        // Good frame 0xA5, then read.
        send_frame(8'hA5, 1'b1, 8);
        wait_cycles(2);
        check_eq("a5_data",  rx_data, 8'hA5);
        check_eq("a5_valid", rx_valid, 1'b1);
        check_eq("a5_ferr",  frame_err, 1'b0);
        check_eq("a5_ovr",   overrun, 1'b0);
        check_eq("a5_busy",  busy, 1'b0);
        do_read();
        check_eq("a5_rd_valid", rx_valid, 1'b0);
        check_eq("a5_rd_data",  rx_data, 8'hA5);

        // Five-cycle low glitch: START is entered, then abandoned at mid-bit.
        @(posedge clk);
        #1 rx_serial = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx_serial = 1'b1;
        check_eq("glitch_busy_mid", busy, 1'b1);
        wait_cycles(20);
        $display("glitch driven");
        check_eq("glitch_busy",  busy, 1'b0);
        check_eq("glitch_valid", rx_valid, 1'b0);
        check_eq("glitch_ferr",  frame_err, 1'b0);
        check_eq("glitch_ovr",   overrun, 1'b0);

        // 0x3C with a zero stop bit, line held low afterwards.
        send_frame(8'h3C, 1'b0, 8);
        wait_cycles(40);
        check_eq("brk_ferr",  frame_err, 1'b1);
        check_eq("brk_valid", rx_valid, 1'b0);
        check_eq("brk_data",  rx_data, 8'hA5);
        check_eq("brk_busy",  busy, 1'b1);
        #1 rx_serial = 1'b1;
        wait_cycles(5);
        check_eq("brk_idle_busy", busy, 1'b0);
        check_eq("brk_sticky",    frame_err, 1'b1);
        check_eq("brk_no_retrig", rx_valid, 1'b0);
        do_read();
        check_eq("brk_rd_ferr", frame_err, 1'b0);

        // 0x11 then 0x22 without a read in between.
        send_frame(8'h11, 1'b1, 8);
        wait_cycles(2);
        check_eq("o11_data", rx_data, 8'h11);
        check_eq("o11_ovr",  overrun, 1'b0);
        send_frame(8'h22, 1'b1, 8);
        wait_cycles(2);
        check_eq("o22_data",  rx_data, 8'h22);
        check_eq("o22_valid", rx_valid, 1'b1);
        check_eq("o22_ovr",   overrun, 1'b1);
        // rd_en without chip select must not count as a read.
        @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        wait_cycles(1);
        check_eq("nocs_valid", rx_valid, 1'b1);
        check_eq("nocs_ovr",   overrun, 1'b1);
        do_read();
        check_eq("o_rd_valid", rx_valid, 1'b0);
        check_eq("o_rd_ovr",   overrun, 1'b0);
        check_eq("o_rd_data",  rx_data, 8'h22);

        // 0x55 left unread, then 0x77 with the read landing on the accept edge.
        // Stop sample is 155 edges after the edge that drives the start bit.
        send_frame(8'h55, 1'b1, 8);
        wait_cycles(2);
        check_eq("p55_valid", rx_valid, 1'b1);
        fork
            send_frame(8'h77, 1'b1, 8);
            begin
                repeat (155) @(posedge clk);
                #1 cs_uart_rx = 1'b1;
                rd_en = 1'b1;
                @(posedge clk);
                #1 cs_uart_rx = 1'b0;
                rd_en = 1'b0;
            end
        join
        wait_cycles(1);
        check_eq("c77_data",  rx_data, 8'h77);
        check_eq("c77_valid", rx_valid, 1'b1);
        check_eq("c77_ovr",   overrun, 1'b0);

        // Reset in the middle of the data bits of 0xF0.
        send_frame(8'hF0, 1'b1, 3);
        wait_cycles(8);
        check_eq("f0_busy_pre", busy, 1'b1);
        rst = 1'b1;
        wait_cycles(1);
        check_eq("mrst_data",  rx_data, 8'h00);
        check_eq("mrst_valid", rx_valid, 1'b0);
        check_eq("mrst_ferr",  frame_err, 1'b0);
        check_eq("mrst_ovr",   overrun, 1'b0);
        check_eq("mrst_busy",  busy, 1'b0);
        rst       = 1'b0;
        rx_serial = 1'b1;
        wait_cycles(5);
        check_eq("mrst_idle_busy", busy, 1'b0);

        // Clean frame after the reset.
        send_frame(8'h0F, 1'b1, 8);
        wait_cycles(2);
        check_eq("f0f_data",  rx_data, 8'h0F);
        check_eq("f0f_valid", rx_valid, 1'b1);
        check_eq("f0f_ferr",  frame_err, 1'b0);
        check_eq("f0f_ovr",   overrun, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
